// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states and instruction constants.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_fetch_responder_imem_array.sv
// Word-addressed instruction store: synchronous preload write, combinational read.
module imem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [INSTR_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [INSTR_W-1:0]       rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Preload write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: accepts PC fetch requests, serves them from a
// one-entry last-address buffer or the instruction store after a fixed miss
// latency, and stalls the PC while a fetch is outstanding.
module imem_fetch_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     req_valid_i,
  input  logic [31:0]              req_addr_i,
  output logic                     req_ready_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [INSTR_W-1:0]       rsp_instr_o,
  output logic [31:0]              rsp_addr_o,
  output logic                     rsp_err_o,
  output logic                     stall_o,
  input  logic                     flush_i,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [INSTR_W-1:0]       load_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  fetch_state_t       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
  logic [31:0]        rsp_addr_q, rsp_addr_d;
  logic               stall_q, stall_d;
  logic               buf_valid_q, buf_valid_d;
  logic [31:0]        buf_addr_q, buf_addr_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;

  logic               req_ready;
  logic               req_err;
  logic               req_hit;
  logic               store_we;
  logic [AW-1:0]      rd_idx;
  logic [INSTR_W-1:0] rd_data;

  assign req_ready = (state_q == IDLE) && start;
  assign req_err   = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));
  assign req_hit   = buf_valid_q && (buf_addr_q == req_addr_i);
  // In IDLE the read port looks at the incoming request so LATENCY=1 can
  // answer a miss on the next edge; otherwise it uses the latched address.
  assign rd_idx    = (state_q == IDLE) ? req_addr_i[2 +: AW] : rsp_addr_q[2 +: AW];

  imem_array #(
    .DEPTH (DEPTH)
  ) u_imem_array (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (load_addr_i),
    .wdata_i (load_data_i),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  // Next-state logic for the fetch FSM, response registers and hit buffer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    stall_d     = stall_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_instr_d = buf_instr_q;
    store_we    = 1'b0;

    case (state_q)
      IDLE: begin
        store_we = load_we_i && !start;
        if (store_we) buf_valid_d = 1'b0;
        if (req_valid_i && req_ready) begin
          rsp_addr_d = req_addr_i;
          stall_d    = 1'b1;
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_instr_d = NOP_INSTR;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (req_hit) begin
            rsp_err_d   = 1'b0;
            rsp_instr_d = buf_instr_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (LATENCY == 1) begin
            rsp_err_d   = 1'b0;
            rsp_instr_d = rd_data;
            rsp_valid_d = 1'b1;
            buf_valid_d = 1'b1;
            buf_addr_d  = req_addr_i;
            buf_instr_d = rd_data;
            state_d     = RESP;
          end else begin
            rsp_err_d = 1'b0;
            cnt_d     = CW'(LATENCY - 1);
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          rsp_valid_d = 1'b0;
          stall_d     = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == '0) begin
          // Errors never reach BUSY, so the buffer is always safe to fill here.
          rsp_instr_d = rd_data;
          rsp_valid_d = 1'b1;
          buf_valid_d = 1'b1;
          buf_addr_d  = rsp_addr_q;
          buf_instr_d = rd_data;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          stall_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        stall_d     = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      stall_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      stall_q     <= stall_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign req_ready_o = req_ready;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign stall_o     = stall_q;

endmodule
